// File: rtl/cpu_bus_responder.sv
// CPU bus target: mirrored work RAM, loadable vector bytes at 0xFFFA-0xFFFF, handshaked PPU register bridge.
// Optional build macro CPU_BUS_RAM_CLEAR_EN adds a post-reset sweep that zeroes the work RAM.
module cpu_bus_responder #(
    parameter int          RAM_ADDR_W    = 11,
    parameter logic [15:0] NMI_VEC_RST   = 16'h8000,
    parameter logic [15:0] RESET_VEC_RST = 16'h8000,
    parameter logic [15:0] IRQ_VEC_RST   = 16'h8000,
    parameter int          PPU_TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_write_en,
    output logic [7:0]  cpu_data_in,
    output logic        cpu_ready,
    output logic [2:0]  ppu_reg_addr,
    output logic [7:0]  ppu_wdata,
    output logic        ppu_we,
    output logic        ppu_re,
    input  logic [7:0]  ppu_rdata,
    input  logic        ppu_ack,
    input  logic        vec_wr_en,
    input  logic [2:0]  vec_sel,
    input  logic [7:0]  vec_wdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        PPU_WAIT,
        PPU_DONE
`ifdef CPU_BUS_RAM_CLEAR_EN
        , INIT
`endif
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(PPU_TIMEOUT - 1);

    state_t                  state;
    logic [7:0]              tmo_cnt;
    logic [7:0]              mem [2**RAM_ADDR_W];
    logic [7:0]              vec [6];
    logic [RAM_ADDR_W-1:0]   ram_idx;
    logic [2:0]              vec_idx;
    logic                    accept;
    logic                    hit_ram;
    logic                    hit_ppu;
    logic                    hit_vec;
`ifdef CPU_BUS_RAM_CLEAR_EN
    logic [RAM_ADDR_W-1:0]   init_ptr;
`endif

    assign accept  = cpu_req && cpu_ready;
    assign hit_ram = (cpu_addr[15:13] == 3'b000);
    assign hit_ppu = (cpu_addr[15:13] == 3'b001);
    assign hit_vec = (cpu_addr >= 16'hFFFA);
    assign ram_idx = cpu_addr[RAM_ADDR_W-1:0];
    // 0xFFFA has low bits 3'b010, so subtracting 2 maps the window onto 0..5
    assign vec_idx = cpu_addr[2:0] - 3'd2;

    // RAM kept out of the reset domain so it maps onto a plain memory macro
    always_ff @(posedge clk) begin
        if (!rst) begin
`ifdef CPU_BUS_RAM_CLEAR_EN
            if (state == INIT)
                mem[init_ptr] <= '0;
            else
`endif
            if (accept && hit_ram && cpu_write_en)
                mem[ram_idx] <= cpu_data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_data_in  <= '0;
            ppu_reg_addr <= '0;
            ppu_wdata    <= '0;
            ppu_we       <= 1'b0;
            ppu_re       <= 1'b0;
            bus_err      <= 1'b0;
            tmo_cnt      <= '0;
            vec[0]       <= NMI_VEC_RST[7:0];
            vec[1]       <= NMI_VEC_RST[15:8];
            vec[2]       <= RESET_VEC_RST[7:0];
            vec[3]       <= RESET_VEC_RST[15:8];
            vec[4]       <= IRQ_VEC_RST[7:0];
            vec[5]       <= IRQ_VEC_RST[15:8];
`ifdef CPU_BUS_RAM_CLEAR_EN
            state        <= INIT;
            cpu_ready    <= 1'b0;
            init_ptr     <= '0;
`else
            state        <= IDLE;
            cpu_ready    <= 1'b1;
`endif
        end else begin
            if (vec_wr_en && vec_sel <= 3'd5)
                vec[vec_sel] <= vec_wdata;

            case (state)
                IDLE, PPU_DONE: begin
                    state     <= IDLE;
                    cpu_ready <= 1'b1;
                    if (accept) begin
                        if (hit_ram && !cpu_write_en)
                            cpu_data_in <= mem[ram_idx];
                        else if (hit_vec && !cpu_write_en)
                            cpu_data_in <= vec[vec_idx];
                        else if (hit_ppu) begin
                            state        <= PPU_WAIT;
                            cpu_ready    <= 1'b0;
                            ppu_reg_addr <= cpu_addr[2:0];
                            ppu_re       <= !cpu_write_en;
                            ppu_we       <= cpu_write_en;
                            ppu_wdata    <= cpu_write_en ? cpu_data_out : 8'h00;
                            tmo_cnt      <= '0;
                        end
                    end
                end
                PPU_WAIT: begin
                    if (ppu_ack || tmo_cnt == TMO_LAST) begin
                        if (ppu_ack && ppu_re)
                            cpu_data_in <= ppu_rdata;
                        if (!ppu_ack)
                            bus_err <= 1'b1;
                        ppu_re    <= 1'b0;
                        ppu_we    <= 1'b0;
                        ppu_wdata <= '0;
                        cpu_ready <= 1'b1;
                        state     <= PPU_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
`ifdef CPU_BUS_RAM_CLEAR_EN
                INIT: begin
                    init_ptr <= init_ptr + 1'b1;
                    if (&init_ptr) begin
                        state     <= IDLE;
                        cpu_ready <= 1'b1;
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    cpu_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: RAM mirror, vector file, PPU handshake/timeout, open bus, reset.
module tb_cpu_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_write_en;
    logic [7:0]  cpu_data_in;
    logic        cpu_ready;
    logic [2:0]  ppu_reg_addr;
    logic [7:0]  ppu_wdata;
    logic        ppu_we;
    logic        ppu_re;
    logic [7:0]  ppu_rdata;
    logic        ppu_ack;
    logic        vec_wr_en;
    logic [2:0]  vec_sel;
    logic [7:0]  vec_wdata;
    logic        bus_err;

    int n_chk  = 0;
    int n_fail = 0;

    cpu_bus_responder dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_write_en (cpu_write_en),
        .cpu_data_in  (cpu_data_in),
        .cpu_ready    (cpu_ready),
        .ppu_reg_addr (ppu_reg_addr),
        .ppu_wdata    (ppu_wdata),
        .ppu_we       (ppu_we),
        .ppu_re       (ppu_re),
        .ppu_rdata    (ppu_rdata),
        .ppu_ack      (ppu_ack),
        .vec_wr_en    (vec_wr_en),
        .vec_sel      (vec_sel),
        .vec_wdata    (vec_wdata),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one request, accepted at the next edge; returns 1 ns after that edge
    task automatic bus(input logic [15:0] a, input logic w, input logic [7:0] d);
        cpu_req      = 1'b1;
        cpu_addr     = a;
        cpu_write_en = w;
        cpu_data_out = d;
        tick();
        cpu_req      = 1'b0;
        cpu_write_en = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!cpu_ready && n < 3000) begin
            tick();
            n++;
        end
        chk(tag, 16'(cpu_ready), 16'd1);
    endtask

    initial begin
        int cnt;
        rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_data_out = '0; cpu_write_en = 1'b0;
        ppu_rdata = '0; ppu_ack = 1'b0; vec_wr_en = 1'b0; vec_sel = '0; vec_wdata = '0;
        tick();
        tick();
        chk("rst_data", 16'(cpu_data_in), 16'h00);
        chk("rst_strobes", {14'd0, ppu_re, ppu_we}, 16'd0);
        chk("rst_ppu_bus", {5'd0, ppu_reg_addr, ppu_wdata}, 16'd0);
        chk("rst_bus_err", 16'(bus_err), 16'd0);
`ifdef CPU_BUS_RAM_CLEAR_EN
        chk("rst_ready", 16'(cpu_ready), 16'd0);
`else
        chk("rst_ready", 16'(cpu_ready), 16'd1);
`endif
        rst = 1'b0;
        wait_ready("init_ready");

        // vectors after reset, little endian
        bus(16'hFFFC, 1'b0, 8'h00); chk("vec_rst_lo", 16'(cpu_data_in), 16'h00);
        bus(16'hFFFD, 1'b0, 8'h00); chk("vec_rst_hi", 16'(cpu_data_in), 16'h80);

        // RAM write and mirrored read
        bus(16'h01FD, 1'b1, 8'h5A);
        bus(16'h09FD, 1'b0, 8'h00);
        chk("ram_mirror", 16'(cpu_data_in), 16'h5A);
        chk("ram_ready", 16'(cpu_ready), 16'd1);
        bus(16'h07FF, 1'b1, 8'hC3);
        bus(16'h1FFF, 1'b0, 8'h00);
        chk("ram_top_mirror", 16'(cpu_data_in), 16'hC3);

        // vector loads, out-of-range select ignored, CPU writes ignored
        vec_wr_en = 1'b1; vec_sel = 3'd2; vec_wdata = 8'h34; tick();
        vec_sel = 3'd3; vec_wdata = 8'h12; tick();
        vec_sel = 3'd6; vec_wdata = 8'hEE; tick();
        vec_wr_en = 1'b0;
        bus(16'hFFFC, 1'b0, 8'h00); chk("vec_ld_lo", 16'(cpu_data_in), 16'h34);
        bus(16'hFFFD, 1'b0, 8'h00); chk("vec_ld_hi", 16'(cpu_data_in), 16'h12);
        bus(16'hFFFC, 1'b1, 8'h99);
        bus(16'hFFFC, 1'b0, 8'h00); chk("vec_cpu_wr_ign", 16'(cpu_data_in), 16'h34);
        bus(16'hFFFA, 1'b0, 8'h00); chk("vec_nmi_lo", 16'(cpu_data_in), 16'h00);
        bus(16'hFFFF, 1'b0, 8'h00); chk("vec_irq_hi", 16'(cpu_data_in), 16'h80);

        // load and read of the same byte in one cycle returns the old byte
        vec_wr_en = 1'b1; vec_sel = 3'd4; vec_wdata = 8'h56;
        bus(16'hFFFE, 1'b0, 8'h00);
        vec_wr_en = 1'b0;
        chk("vec_same_cyc", 16'(cpu_data_in), 16'h00);
        bus(16'hFFFE, 1'b0, 8'h00); chk("vec_after", 16'(cpu_data_in), 16'h56);

        // PPU read, ack on 3rd strobe cycle
        bus(16'h2002, 1'b0, 8'h00);
        chk("ppu_rd_re1", {15'd0, ppu_re}, 16'd1);
        chk("ppu_rd_we", {15'd0, ppu_we}, 16'd0);
        chk("ppu_rd_rdy1", 16'(cpu_ready), 16'd0);
        chk("ppu_rd_addr", 16'(ppu_reg_addr), 16'd2);
        tick();
        chk("ppu_rd_re2", {15'd0, ppu_re}, 16'd1);
        chk("ppu_rd_rdy2", 16'(cpu_ready), 16'd0);
        tick();
        chk("ppu_rd_re3", {15'd0, ppu_re}, 16'd1);
        ppu_ack = 1'b1; ppu_rdata = 8'h80;
        tick();
        ppu_ack = 1'b0; ppu_rdata = 8'h00;
        chk("ppu_rd_re_drop", {15'd0, ppu_re}, 16'd0);
        chk("ppu_rd_rdy_done", 16'(cpu_ready), 16'd1);
        chk("ppu_rd_data", 16'(cpu_data_in), 16'h80);
        tick();
        chk("ppu_rd_rdy_idle", 16'(cpu_ready), 16'd1);

        // PPU write with no ack: timeout after 15 strobe cycles
        bus(16'h3FF9, 1'b1, 8'h1E);
        chk("ppu_wr_data", 16'(ppu_wdata), 16'h1E);
        chk("ppu_wr_addr", 16'(ppu_reg_addr), 16'd1);
        chk("ppu_wr_re", {15'd0, ppu_re}, 16'd0);
        cnt = 0;
        while (ppu_we && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("ppu_tmo_cycles", 16'(cnt), 16'd15);
        chk("ppu_tmo_err", 16'(bus_err), 16'd1);
        chk("ppu_tmo_data", 16'(cpu_data_in), 16'h80);
        chk("ppu_tmo_ready", 16'(cpu_ready), 16'd1);

        // stray ack in IDLE is ignored
        ppu_ack = 1'b1; ppu_rdata = 8'h11; tick(); tick();
        ppu_ack = 1'b0;
        chk("ppu_stray_ack", 16'(cpu_data_in), 16'h80);

        // open bus
        bus(16'h0010, 1'b1, 8'h77);
        bus(16'h0010, 1'b0, 8'h00); chk("ram_0010", 16'(cpu_data_in), 16'h77);
        bus(16'h4800, 1'b1, 8'h33);
        bus(16'h4800, 1'b0, 8'h00);
        chk("open_bus", 16'(cpu_data_in), 16'h77);
        chk("open_ready", 16'(cpu_ready), 16'd1);
        bus(16'hFFF9, 1'b0, 8'h00); chk("open_fff9", 16'(cpu_data_in), 16'h77);

        // reset mid PPU_WAIT
        bus(16'h2007, 1'b0, 8'h00);
        tick();
        chk("pre_rst_re", {15'd0, ppu_re}, 16'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_re", {14'd0, ppu_re, ppu_we}, 16'd0);
        chk("mid_rst_err", 16'(bus_err), 16'd0);
`ifdef CPU_BUS_RAM_CLEAR_EN
        chk("mid_rst_ready", 16'(cpu_ready), 16'd0);
`else
        chk("mid_rst_ready", 16'(cpu_ready), 16'd1);
`endif
        rst = 1'b0;
        wait_ready("post_rst_ready");
        bus(16'hFFFC, 1'b0, 8'h00); chk("post_rst_vec_lo", 16'(cpu_data_in), 16'h00);
        bus(16'hFFFD, 1'b0, 8'h00); chk("post_rst_vec_hi", 16'(cpu_data_in), 16'h80);
`ifdef CPU_BUS_RAM_CLEAR_EN
        bus(16'h01FD, 1'b0, 8'h00); chk("ram_cleared", 16'(cpu_data_in), 16'h00);
`else
        bus(16'h01FD, 1'b0, 8'h00); chk("ram_kept", 16'(cpu_data_in), 16'h5A);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
